// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and constants for the 5-stage core's hazard logic.
//   - fwd_sel_t  : operand forwarding select (RF / writeback / memory stage)
//   - hz_state_t : hazard sequencer state
//   - RES_SRC_MEM: ResultSrc encoding that marks a load
//   - REG_ZERO   : hard-wired zero register, never forwarded or hazarded
// -----------------------------------------------------------------------------
package pipeline_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LSTALL = 2'd1,
      MWAIT  = 2'd2
   } hz_state_t;

   localparam logic [1:0] RES_SRC_MEM = 2'b01;
   localparam logic [4:0] REG_ZERO    = 5'd0;

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
//   Combinational forwarding select for one Execute-stage source operand.
//   Ports:
//     rs        in  5  source register of the operand in Execute
//     rdM       in  5  destination register in Memory
//     regWriteM in  1  Memory instruction writes a register
//     rdW       in  5  destination register in Writeback
//     regWriteW in  1  Writeback instruction writes a register
//     fwdSel    out 2  00 register file, 10 ALUResultM, 01 ResultW
// -----------------------------------------------------------------------------
module forward_unit
   import pipeline_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rdM,
   input  logic       regWriteM,
   input  logic [4:0] rdW,
   input  logic       regWriteW,
   output logic [1:0] fwdSel
);

   fwd_sel_t sel;

   // Memory stage holds the younger result, so it wins over Writeback.
   always_comb begin
      sel = FWD_RF;
      if (rs != REG_ZERO) begin
         if (regWriteM && (rdM == rs)) begin
            sel = FWD_M;
         end else if (regWriteW && (rdW == rs)) begin
            sel = FWD_W;
         end
      end
   end

   assign fwdSel = sel;

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Pipeline hazard sequencer: operand forwarding, load-use stalls with
//   LOAD_LAT bubbles, branch/jump flushes, whole-pipe freeze on a busy data
//   memory, and saturating stall/flush event counters.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     Rs1D, Rs2D                 Decode source registers
//     Rs1E, Rs2E, RdE            Execute source/destination registers
//     RdM, RdW                   Memory / Writeback destination registers
//     ResultSrcE                 Execute result source (01 = load)
//     RegWriteM, RegWriteW       register write enables in M / W
//     PCSrcE                     taken branch or jump in Execute
//     MemBusyM                   data memory not ready
//     ForwardAE, ForwardBE       operand forwarding selects
//     StallF/D/E/M               stage register holds
//     FlushD, FlushE             stage register clears
//     StallCnt, FlushCnt         saturating debug event counters
//   All control outputs are combinational from registered state plus the
//   current inputs so they reach the stage enables in the same cycle.
// -----------------------------------------------------------------------------
module hazard_controller
   import pipeline_pkg::*;
#(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic [1:0]       ResultSrcE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcE,
   input  logic             MemBusyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   // Bubbles still owed after the detecting cycle itself.
   localparam logic [2:0]       BUBBLES_AFTER = 3'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX       = '1;

   hz_state_t        stateReg, stateNext;
   hz_state_t        savedStateReg, savedStateNext;
   hz_state_t        effState;
   logic [2:0]       bcntReg, bcntNext;
   logic [2:0]       savedBcntReg, savedBcntNext;
   logic [2:0]       effBcnt;
   logic [CNT_W-1:0] stallCntReg, stallCntNext;
   logic [CNT_W-1:0] flushCntReg, flushCntNext;
   logic             luse;
   logic             branchFlush;
   logic [1:0]       fwdA, fwdB;

   forward_unit uFwdA (
      .rs        (Rs1E),
      .rdM       (RdM),
      .regWriteM (RegWriteM),
      .rdW       (RdW),
      .regWriteW (RegWriteW),
      .fwdSel    (fwdA)
   );

   forward_unit uFwdB (
      .rs        (Rs2E),
      .rdM       (RdM),
      .regWriteM (RegWriteM),
      .rdW       (RdW),
      .regWriteW (RegWriteW),
      .fwdSel    (fwdB)
   );

   always_comb begin
      luse = (ResultSrcE == RES_SRC_MEM) && (RdE != REG_ZERO) &&
             ((RdE == Rs1D) || (RdE == Rs2D));

      // On the cycle memory becomes ready again, act exactly as the saved
      // state would have, so the freeze neither eats nor adds a bubble.
      effState = (stateReg == MWAIT) ? savedStateReg : stateReg;
      effBcnt  = (stateReg == MWAIT) ? savedBcntReg  : bcntReg;

      ForwardAE      = fwdA;
      ForwardBE      = fwdB;
      StallF         = 1'b0;
      StallD         = 1'b0;
      StallE         = 1'b0;
      StallM         = 1'b0;
      FlushD         = 1'b0;
      FlushE         = 1'b0;
      branchFlush    = 1'b0;
      stateNext      = stateReg;
      bcntNext       = bcntReg;
      savedStateNext = savedStateReg;
      savedBcntNext  = savedBcntReg;

      if (reset) begin
         ForwardAE      = FWD_RF;
         ForwardBE      = FWD_RF;
         FlushD         = 1'b1;
         FlushE         = 1'b1;
         stateNext      = RUN;
         bcntNext       = 3'd0;
         savedStateNext = RUN;
         savedBcntNext  = 3'd0;
      end else if (MemBusyM) begin
         StallF    = 1'b1;
         StallD    = 1'b1;
         StallE    = 1'b1;
         StallM    = 1'b1;
         stateNext = MWAIT;
         // Only capture on entry; later busy cycles would overwrite with MWAIT.
         if (stateReg != MWAIT) begin
            savedStateNext = stateReg;
            savedBcntNext  = bcntReg;
         end
      end else if (PCSrcE) begin
         FlushD      = 1'b1;
         FlushE      = 1'b1;
         branchFlush = 1'b1;
         stateNext   = RUN;
         bcntNext    = 3'd0;
      end else if (effState == LSTALL) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
         if (effBcnt <= 3'd1) begin
            stateNext = RUN;
            bcntNext  = 3'd0;
         end else begin
            stateNext = LSTALL;
            bcntNext  = effBcnt - 3'd1;
         end
      end else begin
         stateNext = RUN;
         bcntNext  = 3'd0;
         if (luse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            if (LOAD_LAT > 1) begin
               stateNext = LSTALL;
               bcntNext  = BUBBLES_AFTER;
            end
         end
      end

      stallCntNext = stallCntReg;
      if (StallF && (stallCntReg != CNT_MAX)) begin
         stallCntNext = stallCntReg + CNT_W'(1);
      end
      flushCntNext = flushCntReg;
      if (branchFlush && (flushCntReg != CNT_MAX)) begin
         flushCntNext = flushCntReg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg      <= RUN;
         bcntReg       <= 3'd0;
         savedStateReg <= RUN;
         savedBcntReg  <= 3'd0;
         stallCntReg   <= '0;
         flushCntReg   <= '0;
      end else begin
         stateReg      <= stateNext;
         bcntReg       <= bcntNext;
         savedStateReg <= savedStateNext;
         savedBcntReg  <= savedBcntNext;
         stallCntReg   <= stallCntNext;
         flushCntReg   <= flushCntNext;
      end
   end

   assign StallCnt = stallCntReg;
   assign FlushCnt = flushCntReg;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0] ResultSrcE;
   logic       RegWriteM, RegWriteW, PCSrcE, MemBusyM;

   // Instance 0: LOAD_LAT=1, instance 1: LOAD_LAT=3, instance 2: LOAD_LAT=1 with 4-bit counters
   logic [1:0]  fwdA [3];
   logic [1:0]  fwdB [3];
   logic        stF [3];
   logic        stD [3];
   logic        stE [3];
   logic        stM [3];
   logic        flD [3];
   logic        flE [3];
   logic [15:0] sCnt [2];
   logic [15:0] fCnt [2];
   logic [3:0]  sCntS, fCntS;
   logic [41:0] obs [3];

   int vectors = 0;
   int miscompares = 0;

   hazard_controller #(.LOAD_LAT(1), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
      .ForwardAE(fwdA[0]), .ForwardBE(fwdB[0]), .StallF(stF[0]), .StallD(stD[0]),
      .StallE(stE[0]), .StallM(stM[0]), .FlushD(flD[0]), .FlushE(flE[0]),
      .StallCnt(sCnt[0]), .FlushCnt(fCnt[0]));

   hazard_controller #(.LOAD_LAT(3), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
      .ForwardAE(fwdA[1]), .ForwardBE(fwdB[1]), .StallF(stF[1]), .StallD(stD[1]),
      .StallE(stE[1]), .StallM(stM[1]), .FlushD(flD[1]), .FlushE(flE[1]),
      .StallCnt(sCnt[1]), .FlushCnt(fCnt[1]));

   hazard_controller #(.LOAD_LAT(1), .CNT_W(4)) dut2 (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
      .ForwardAE(fwdA[2]), .ForwardBE(fwdB[2]), .StallF(stF[2]), .StallD(stD[2]),
      .StallE(stE[2]), .StallM(stM[2]), .FlushD(flD[2]), .FlushE(flE[2]),
      .StallCnt(sCntS), .FlushCnt(fCntS));

   assign obs[0] = {fwdA[0], fwdB[0], stF[0], stD[0], stE[0], stM[0], flD[0], flE[0], sCnt[0], fCnt[0]};
   assign obs[1] = {fwdA[1], fwdB[1], stF[1], stD[1], stE[1], stM[1], flD[1], flE[1], sCnt[1], fCnt[1]};
   assign obs[2] = {fwdA[2], fwdB[2], stF[2], stD[2], stE[2], stM[2], flD[2], flE[2], 12'd0, sCntS, 12'd0, fCntS};

   // ---------------- reference model ----------------
   // Each instance is described by how many bubbles it still owes and two counters.
   int lat  [3] = '{1, 3, 1};
   int cmax [3] = '{65535, 65535, 15};
   int pend [3] = '{0, 0, 0};
   int sc   [3] = '{0, 0, 0};
   int fc   [3] = '{0, 0, 0};
   int pendN[3], scN[3], fcN[3];
   logic [41:0] expv [3];

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (rs == 5'd0) return 2'b00;
      if (RegWriteM && RdM == rs) return 2'b10;
      if (RegWriteW && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_eval();
      bit luse;
      luse = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
      for (int i = 0; i < 3; i++) begin
         logic [1:0] fa, fb;
         bit sf, sd, se, sm, fd, fe;
         fa = fwd_ref(Rs1E); fb = fwd_ref(Rs2E);
         sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0;
         pendN[i] = pend[i]; scN[i] = sc[i]; fcN[i] = fc[i];
         if (reset) begin
            fa = 2'b00; fb = 2'b00; fd = 1; fe = 1;
            pendN[i] = 0; scN[i] = 0; fcN[i] = 0;
         end else if (MemBusyM) begin
            sf = 1; sd = 1; se = 1; sm = 1;
         end else if (PCSrcE) begin
            fd = 1; fe = 1; pendN[i] = 0;
            if (fc[i] < cmax[i]) fcN[i] = fc[i] + 1;
         end else if (pend[i] > 0) begin
            sf = 1; sd = 1; fe = 1; pendN[i] = pend[i] - 1;
         end else if (luse) begin
            sf = 1; sd = 1; fe = 1; pendN[i] = lat[i] - 1;
         end
         if (!reset && sf && sc[i] < cmax[i]) scN[i] = sc[i] + 1;
         expv[i] = {fa, fb, sf, sd, se, sm, fd, fe, 16'(sc[i]), 16'(fc[i])};
      end
   endtask

   task automatic model_commit();
      for (int i = 0; i < 3; i++) begin
         pend[i] = pendN[i]; sc[i] = scN[i]; fc[i] = fcN[i];
      end
   endtask

   // Evaluate at the falling edge, far from the active edge.
   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic idle();
      reset = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemBusyM = 0;
   endtask

   task automatic load_use();
      ResultSrcE = 2'b01; RdE = 5'd3; Rs2D = 5'd3;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      settle();
      advance();
      reset = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      reset = 1;
      for (int s = 0; s < 2; s++) begin
         settle();
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
               miscompares++;
               $display("FAIL reset[%0d] inst%0d: got %h want %h", s, i, obs[i], expv[i]);
            end
         end
         vectors++;
         if ({stF[0], stM[0], flD[0], flE[0]} !== 4'b0011) begin
            miscompares++;
            $display("FAIL reset_ctrl[%0d]: got %b want 0011", s, {stF[0], stM[0], flD[0], flE[0]});
         end
         $display("reset step %0d: StallF=%b FlushD=%b FlushE=%b", s, stF[0], flD[0], flE[0]);
         advance();
      end
      reset = 0;
      settle();
      vectors++;
      if (sCnt[0] !== 16'd0 || fCnt[0] !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_cnt: got %0d/%0d want 0/0", sCnt[0], fCnt[0]);
      end
      advance();
   endtask

   task automatic test_forwarding();
      logic [1:0] want [3] = '{2'b10, 2'b01, 2'b00};
      logic       wm   [3] = '{1'b1, 1'b0, 1'b1};
      logic [4:0] rd   [3] = '{5'd5, 5'd5, 5'd0};
      for (int s = 0; s < 3; s++) begin
         idle();
         RegWriteM = wm[s]; RdM = rd[s]; RegWriteW = 1; RdW = rd[s];
         Rs1E = rd[s]; Rs2E = rd[s];
         settle();
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
               miscompares++;
               $display("FAIL fwd[%0d] inst%0d: got %h want %h", s, i, obs[i], expv[i]);
            end
         end
         vectors++;
         if (fwdA[0] !== want[s] || fwdB[0] !== want[s]) begin
            miscompares++;
            $display("FAIL fwd_sel[%0d]: got A=%b B=%b want %b", s, fwdA[0], fwdB[0], want[s]);
         end
         $display("fwd step %0d: ForwardAE=%b ForwardBE=%b", s, fwdA[0], fwdB[0]);
         advance();
      end
   endtask

   task automatic test_load_use_lat1();
      logic wantF [3] = '{1'b1, 1'b0, 1'b0};
      do_reset();
      for (int s = 0; s < 3; s++) begin
         idle();
         if (s == 0) load_use();
         settle();
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
               miscompares++;
               $display("FAIL luse1[%0d] inst%0d: got %h want %h", s, i, obs[i], expv[i]);
            end
         end
         vectors++;
         if (stF[0] !== wantF[s] || stD[0] !== wantF[s] || flE[0] !== wantF[s]) begin
            miscompares++;
            $display("FAIL luse1_stall[%0d]: got %b%b%b want %b", s, stF[0], stD[0], flE[0], wantF[s]);
         end
         $display("luse1 step %0d: StallF=%b StallCnt=%0d", s, stF[0], sCnt[0]);
         advance();
      end
      settle();
      vectors++;
      if (sCnt[0] !== 16'd1) begin
         miscompares++;
         $display("FAIL luse1_cnt: got %0d want 1", sCnt[0]);
      end
      advance();
   endtask

   task automatic test_lat3_branch();
      logic wantF [3] = '{1'b1, 1'b0, 1'b0};
      logic wantD [3] = '{1'b0, 1'b1, 1'b0};
      do_reset();
      for (int s = 0; s < 3; s++) begin
         idle();
         if (s == 0) load_use();
         if (s == 1) PCSrcE = 1;
         settle();
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
               miscompares++;
               $display("FAIL br3[%0d] inst%0d: got %h want %h", s, i, obs[i], expv[i]);
            end
         end
         vectors++;
         if (stF[1] !== wantF[s] || flD[1] !== wantD[s]) begin
            miscompares++;
            $display("FAIL br3_ctrl[%0d]: got StallF=%b FlushD=%b want %b %b", s, stF[1], flD[1], wantF[s], wantD[s]);
         end
         $display("br3 step %0d: StallF=%b FlushD=%b FlushE=%b FlushCnt=%0d", s, stF[1], flD[1], flE[1], fCnt[1]);
         advance();
      end
      settle();
      vectors++;
      if (fCnt[1] !== 16'd1) begin
         miscompares++;
         $display("FAIL br3_flushcnt: got %0d want 1", fCnt[1]);
      end
      advance();
   endtask

   task automatic test_membusy_lstall();
      logic wantF [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
      logic wantM [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
      logic wantE [8] = '{1, 0, 0, 0, 0, 1, 1, 0};
      do_reset();
      for (int s = 0; s < 8; s++) begin
         idle();
         if (s == 0) load_use();
         if (s >= 1 && s <= 4) MemBusyM = 1;
         settle();
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
               miscompares++;
               $display("FAIL mbusy[%0d] inst%0d: got %h want %h", s, i, obs[i], expv[i]);
            end
         end
         vectors++;
         if (stF[1] !== wantF[s] || stM[1] !== wantM[s] || stE[1] !== wantM[s] || flE[1] !== wantE[s]) begin
            miscompares++;
            $display("FAIL mbusy_ctrl[%0d]: got F=%b E=%b M=%b FlE=%b want %b %b %b %b", s,
                     stF[1], stE[1], stM[1], flE[1], wantF[s], wantM[s], wantM[s], wantE[s]);
         end
         $display("mbusy step %0d: StallF=%b StallM=%b FlushE=%b", s, stF[1], stM[1], flE[1]);
         advance();
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      for (int s = 0; s < 4; s++) begin
         idle();
         if (s == 0) load_use();
         if (s == 1) reset = 1;
         settle();
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
               miscompares++;
               $display("FAIL rstmid[%0d] inst%0d: got %h want %h", s, i, obs[i], expv[i]);
            end
         end
         if (s >= 1) begin
            vectors++;
            if (stF[1] !== 1'b0 || flD[1] !== (s == 1) || flE[1] !== (s == 1)) begin
               miscompares++;
               $display("FAIL rstmid_ctrl[%0d]: got StallF=%b FlushD=%b FlushE=%b", s, stF[1], flD[1], flE[1]);
            end
         end
         if (s >= 2) begin
            vectors++;
            if (sCnt[1] !== 16'd0) begin
               miscompares++;
               $display("FAIL rstmid_cnt[%0d]: got %0d want 0", s, sCnt[1]);
            end
         end
         $display("rstmid step %0d: StallF=%b FlushD=%b StallCnt=%0d", s, stF[1], flD[1], sCnt[1]);
         advance();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int s = 0; s < 23; s++) begin
         idle();
         load_use();
         settle();
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
               miscompares++;
               $display("FAIL sat[%0d] inst%0d: got %h want %h", s, i, obs[i], expv[i]);
            end
         end
         vectors++;
         if (int'(sCntS) != ((s < 15) ? s : 15)) begin
            miscompares++;
            $display("FAIL sat_cnt[%0d]: got %0d want %0d", s, sCntS, (s < 15) ? s : 15);
         end
         $display("sat step %0d: StallF=%b StallCnt=%0d", s, stF[2], sCntS);
         advance();
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 600; s++) begin
         reset      = ($urandom_range(63) == 0);
         MemBusyM   = ($urandom_range(5) == 0);
         PCSrcE     = ($urandom_range(7) == 0);
         Rs1D = 5'($urandom_range(3)); Rs2D = 5'($urandom_range(3));
         Rs1E = 5'($urandom_range(3)); Rs2E = 5'($urandom_range(3));
         RdE  = 5'($urandom_range(3)); RdM  = 5'($urandom_range(3));
         RdW  = 5'($urandom_range(3));
         ResultSrcE = 2'($urandom_range(3));
         RegWriteM  = 1'($urandom_range(1));
         RegWriteW  = 1'($urandom_range(1));
         settle();
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin
               miscompares++;
               $display("FAIL rand[%0d] inst%0d: got %h want %h", s, i, obs[i], expv[i]);
            end
         end
         $display("rand step %0d: obs0=%h obs1=%h obs2=%h", s, obs[0], obs[1], obs[2]);
         advance();
      end
   endtask

   initial begin
      idle();
      #1;
      test_reset();
      test_forwarding();
      test_load_use_lat1();
      test_lat3_branch();
      test_membusy_lstall();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
